// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word-indexed DataMemory access, load extension, SB/SH via read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW/SW instead of ignoring low address bits.
module mem_stage_lsu #(
  parameter int DEPTH = 2046,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] mem_raddr_o,
  output logic            mem_re_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] mem_waddr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_we_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] DepthW = XLEN'(DEPTH);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rmwAddr_q, rmwAddr_d;
  logic [XLEN-1:0] rmwData_q, rmwData_d;
  logic [XLEN-1:0] wbData_q, wbData_d;
  logic [4:0]      wbRd_q, wbRd_d;
  logic            wbValid_q, wbValid_d;
  logic            err_q, err_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] wordIdx;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] mergedWord;
  logic [7:0]      byteLane;
  logic [15:0]     halfLane;
  logic            isByte, isHalf, isWord, sizeOk;
  logic            inRange, misaligned, memOp, accept;

  assign wordIdx  = {2'b00, addr_i[XLEN-1:2]};
  assign isByte   = (funct3_i[1:0] == 2'b00);
  assign isHalf   = (funct3_i[1:0] == 2'b01);
  assign isWord   = (funct3_i[1:0] == 2'b10);
  assign sizeOk   = isByte | isHalf | isWord;
  assign inRange  = (wordIdx < DepthW);
  assign byteLane = mem_rdata_i[{addr_i[1:0], 3'b000} +: 8];
  assign halfLane = mem_rdata_i[{addr_i[1], 4'b0000} +: 16];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_load_i & isHalf & addr_i[0]) | (isWord & (addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // An op is taken only in IDLE; reset and flush kill every side effect of the cycle.
  assign memOp  = rst_n & valid_i & ~flush_i & (state_q == IDLE) & sizeOk & (is_load_i | is_store_i);
  assign accept = memOp & ~misaligned;

  always_comb begin
    loadData = '0;
    if (inRange) begin
      if (isByte)
        loadData = funct3_i[2] ? {{(XLEN-8){1'b0}}, byteLane} : {{(XLEN-8){byteLane[7]}}, byteLane};
      else if (isHalf)
        loadData = funct3_i[2] ? {{(XLEN-16){1'b0}}, halfLane} : {{(XLEN-16){halfLane[15]}}, halfLane};
      else
        loadData = mem_rdata_i;
    end
  end

  // Old word with the addressed byte/half lane replaced by the store data.
  always_comb begin
    mergedWord = mem_rdata_i;
    if (isByte)
      mergedWord[{addr_i[1:0], 3'b000} +: 8] = wdata_i[7:0];
    else
      mergedWord[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
  end

  always_comb begin
    state_d     = state_q;
    rmwAddr_d   = rmwAddr_q;
    rmwData_d   = rmwData_q;
    wbValid_d   = 1'b0;
    wbRd_d      = '0;
    wbData_d    = '0;
    err_d       = 1'b0;
    misalign_d  = memOp & misaligned;
    stall_o     = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_raddr_o = wordIdx;
    mem_waddr_o = wordIdx;
    mem_wdata_o = wdata_i;
    case (state_q)
      IDLE: begin
        if (accept && is_load_i) begin
          mem_re_o  = inRange;
          wbValid_d = 1'b1;
          wbRd_d    = rd_i;
          wbData_d  = loadData;
          err_d     = ~inRange;
        end else if (accept && is_store_i) begin
          err_d = ~inRange;
          if (inRange && isWord) begin
            mem_we_o = 1'b1;
          end else if (inRange) begin
            mem_re_o  = 1'b1;
            stall_o   = 1'b1;
            rmwAddr_d = wordIdx;
            rmwData_d = mergedWord;
            state_d   = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_waddr_o = rmwAddr_q;
        mem_wdata_o = rmwData_q;
        mem_we_o    = rst_n & ~flush_i;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rmwAddr_q  <= '0;
      rmwData_q  <= '0;
      wbValid_q  <= 1'b0;
      wbRd_q     <= '0;
      wbData_q   <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rmwAddr_q  <= rmwAddr_d;
      rmwData_q  <= rmwData_d;
      wbValid_q  <= wbValid_d;
      wbRd_q     <= wbRd_d;
      wbData_q   <= wbData_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_valid_o = wbValid_q;
  assign wb_rd_o    = wbRd_q;
  assign wb_data_o  = wbData_q;
  assign err_o      = err_q;
  assign misalign_o = misalign_q;

endmodule
